// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, flag bit positions, FSM states.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_CMP = 3'd1;
    localparam logic [2:0] OP_SUB = 3'd2;
    localparam logic [2:0] OP_INC = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4;
    localparam logic [2:0] OP_OR  = 3'd5;
    localparam logic [2:0] OP_XOR = 3'd6;
    localparam logic [2:0] OP_MUL = 3'd7;

    localparam int FLG_C = 0;
    localparam int FLG_Z = 1;
    localparam int FLG_N = 2;
    localparam int FLG_V = 3;

    // state    | meaning
    // ST_IDLE  | ready for an operation; single-cycle ops complete here
    // ST_MULT  | shift-add multiply iterating, inputs ignored
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MULT = 1'b1
    } state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier: one partial product per cycle, multiplier LSB first.
// o_done is asserted during the last iteration and o_product already includes that
// iteration's partial product, so the caller can register the final value on that edge.
module alu_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_start,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    output logic               o_done,
    output logic [2*WIDTH-1:0] o_product
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] r_mcand;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_mplier;
    logic [CW-1:0]      r_cnt;
    logic               r_run;
    logic [2*WIDTH-1:0] w_acc_next;

    assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    assign o_done     = r_run & (r_cnt == CW'(1));
    assign o_product  = w_acc_next;

    // Load operands on start, then shift and accumulate while the down-counter runs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand  <= '0;
            r_acc    <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_run    <= 1'b0;
        end else if (i_start) begin
            r_mcand  <= {{WIDTH{1'b0}}, i_a};
            r_acc    <= '0;
            r_mplier <= i_b;
            r_cnt    <= CW'(WIDTH);
            r_run    <= 1'b1;
        end else if (r_run) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt - 1'b1;
            if (r_cnt == CW'(1)) begin
                r_run <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshake, sticky {V,N,Z,C} flags and an optional
// multi-cycle multiply. Single-cycle ops register their result on the accepting edge.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int MUL_EN = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic [3:0]       flags,
    output logic             busy
);

    localparam logic MUL_ON = (MUL_EN != 0);
    localparam int   MSB    = WIDTH - 1;

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_result;
    logic [WIDTH-1:0]   r_result_hi;
    logic [3:0]         r_flags;
    logic               r_out_valid;

    logic               w_accept;
    logic               w_is_mul;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH-1:0]   w_res;
    logic               w_c;
    logic               w_v;
    logic [3:0]         w_flags;
    logic               w_mul_done;
    logic [2*WIDTH-1:0] w_mul_prod;
    logic [WIDTH-1:0]   w_prod_hi;
    logic [3:0]         w_mul_flags;

    assign in_ready  = (r_state == ST_IDLE) & (~r_out_valid | out_ready);
    assign w_accept  = in_valid & in_ready;
    assign w_is_mul  = (op == OP_MUL);
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign result_hi = r_result_hi;
    assign flags     = r_flags;
    assign busy      = (r_state == ST_MULT);

    // Single-cycle datapath; CMP shares the subtractor and only its flags are kept.
    always_comb begin
        w_sum = '0;
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        case (op)
            OP_ADD: begin
                w_sum = {1'b0, a} + {1'b0, b};
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_v   = (a[MSB] == b[MSB]) && (w_res[MSB] != a[MSB]);
            end
            OP_INC: begin
                w_sum = {1'b0, a} + {{WIDTH{1'b0}}, 1'b1};
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_v   = !a[MSB] && w_res[MSB];
            end
            OP_SUB, OP_CMP: begin
                w_sum = {1'b0, a} - {1'b0, b};
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_v   = (a[MSB] != b[MSB]) && (w_res[MSB] != a[MSB]);
            end
            OP_AND:  w_res = a & b;
            OP_OR:   w_res = a | b;
            OP_XOR:  w_res = a ^ b;
            default: w_res = '0;
        endcase
    end

    // Flag word for single-cycle ops; a MUL reaching here (multiplier absent) reports zero.
    always_comb begin
        w_flags        = '0;
        w_flags[FLG_C] = w_c;
        w_flags[FLG_Z] = (w_res == '0);
        w_flags[FLG_N] = w_res[MSB];
        w_flags[FLG_V] = w_v;
        if (w_is_mul) begin
            w_flags = '0;
        end
    end

    assign w_prod_hi = w_mul_prod[2*WIDTH-1:WIDTH];

    // Multiply flags come from the full product.
    always_comb begin
        w_mul_flags        = '0;
        w_mul_flags[FLG_C] = (w_prod_hi != '0);
        w_mul_flags[FLG_Z] = (w_mul_prod == '0);
        w_mul_flags[FLG_N] = w_prod_hi[MSB];
        w_mul_flags[FLG_V] = 1'b0;
    end

    generate
        if (MUL_ON) begin : g_mul
            logic w_mul_start;
            assign w_mul_start = w_accept & w_is_mul;
            alu_mul_seq #(
                .WIDTH (WIDTH)
            ) u_mul (
                .clk       (clk),
                .rst_n     (rst_n),
                .i_start   (w_mul_start),
                .i_a       (a),
                .i_b       (b),
                .o_done    (w_mul_done),
                .o_product (w_mul_prod)
            );
        end else begin : g_nomul
            assign w_mul_done = 1'b0;
            assign w_mul_prod = '0;
        end
    endgenerate

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state: MUL enters MULT only when the multiplier exists.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && w_is_mul && MUL_ON) begin
                    w_state_next = ST_MULT;
                end
            end
            ST_MULT: begin
                if (w_mul_done) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Output and flag registers; a completion on the consuming edge keeps out_valid high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result    <= '0;
            r_result_hi <= '0;
            r_flags     <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_accept && !(w_is_mul && MUL_ON)) begin
                r_out_valid <= 1'b1;
                r_flags     <= w_flags;
                if (op != OP_CMP) begin
                    r_result    <= w_res;
                    r_result_hi <= '0;
                end
            end else if ((r_state == ST_MULT) && w_mul_done) begin
                r_out_valid <= 1'b1;
                r_result    <= w_mul_prod[WIDTH-1:0];
                r_result_hi <= w_prod_hi;
                r_flags     <= w_mul_flags;
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: two instances (8-bit with multiplier, 16-bit without) share stimulus
// and are checked every cycle against an arithmetic reference model.
module tb_alu_seq;

    localparam int OPADD = 0, OPCMP = 1, OPSUB = 2, OPINC = 3;
    localparam int OPAND = 4, OPOR = 5, OPXOR = 6, OPMUL = 7;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid_s = 1'b0;
    logic        out_ready_s = 1'b0;
    logic [2:0]  op_s = 3'd0;
    logic [15:0] a_s = 16'd0;
    logic [15:0] b_s = 16'd0;

    logic        rdy8, ov8, busy8;
    logic [7:0]  res8, hi8;
    logic [3:0]  fl8;
    logic        rdy16, ov16, busy16;
    logic [15:0] res16, hi16;
    logic [3:0]  fl16;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(8), .MUL_EN(1)) u_d8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s), .in_ready(rdy8), .op(op_s),
        .a(a_s[7:0]), .b(b_s[7:0]), .out_valid(ov8), .out_ready(out_ready_s),
        .result(res8), .result_hi(hi8), .flags(fl8), .busy(busy8)
    );

    alu_seq #(.WIDTH(16), .MUL_EN(0)) u_d16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s), .in_ready(rdy16), .op(op_s),
        .a(a_s), .b(b_s), .out_valid(ov16), .out_ready(out_ready_s),
        .result(res16), .result_hi(hi16), .flags(fl16), .busy(busy16)
    );

    int total = 0;
    int bad = 0;

    function automatic void chk(input string name, input longint got, input longint exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, got, exp, $time);
        end
    endfunction

    // Reference model state, index 0 = 8-bit/MUL, index 1 = 16-bit/no MUL.
    int     mw[2] = '{8, 16};
    bit     me[2] = '{1'b1, 1'b0};
    bit     m_valid[2];
    int     m_busy[2];
    longint m_res[2], m_hi[2], p_res[2], p_hi[2];
    int     m_fl[2], p_fl[2];
    bit     m_acc[2];

    task automatic ref_op(input int w, input bit mul_on, input int op, input longint ai,
                          input longint bi, input longint prev_res, input longint prev_hi,
                          output longint res, output longint hi, output int fl);
        longint mask, a, b, s, p;
        int c, v, z, n, sa, sb, sr;
        mask = (longint'(1) << w) - 1;
        a = ai & mask;
        b = bi & mask;
        res = 0; hi = 0; c = 0; v = 0; s = 0;
        if (op == OPINC) b = 1;
        case (op)
            OPADD, OPINC: begin s = a + b; res = s & mask; c = int'((s >> w) & 1); end
            OPSUB, OPCMP: begin s = a - b; res = s & mask; c = (a < b) ? 1 : 0; end
            OPAND: res = a & b;
            OPOR:  res = a | b;
            OPXOR: res = a ^ b;
            default: res = 0;
        endcase
        sa = int'((a >> (w - 1)) & 1);
        sb = int'((b >> (w - 1)) & 1);
        sr = int'((res >> (w - 1)) & 1);
        if (op == OPADD || op == OPINC) v = (sa == sb && sr != sa) ? 1 : 0;
        if (op == OPSUB || op == OPCMP) v = (sa != sb && sr != sa) ? 1 : 0;
        z = (res == 0) ? 1 : 0;
        n = sr;
        if (op == OPMUL) begin
            if (mul_on) begin
                p = a * b;
                res = p & mask;
                hi = (p >> w) & mask;
                c = (hi != 0) ? 1 : 0;
                z = (p == 0) ? 1 : 0;
                n = int'((hi >> (w - 1)) & 1);
                v = 0;
            end else begin
                res = 0; hi = 0; c = 0; z = 0; n = 0; v = 0;
            end
        end
        fl = (v << 3) | (n << 2) | (z << 1) | c;
        if (op == OPCMP) begin
            res = prev_res;
            hi = prev_hi;
        end
    endtask

    // Model update on each rising edge.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            bit rdy;
            longint r, h;
            int f;
            if (!rst_n) begin
                m_valid[k] = 0; m_busy[k] = 0; m_res[k] = 0; m_hi[k] = 0; m_fl[k] = 0;
                m_acc[k] = 0;
            end else begin
                rdy = (m_busy[k] == 0) && (!m_valid[k] || out_ready_s);
                m_acc[k] = in_valid_s && rdy;
                if (m_valid[k] && out_ready_s) m_valid[k] = 0;
                if (m_busy[k] > 0) begin
                    m_busy[k]--;
                    if (m_busy[k] == 0) begin
                        m_valid[k] = 1; m_res[k] = p_res[k]; m_hi[k] = p_hi[k]; m_fl[k] = p_fl[k];
                    end
                end else if (m_acc[k]) begin
                    ref_op(mw[k], me[k], int'(op_s), longint'(a_s), longint'(b_s),
                           m_res[k], m_hi[k], r, h, f);
                    if (op_s == 3'(OPMUL) && me[k]) begin
                        m_busy[k] = mw[k]; p_res[k] = r; p_hi[k] = h; p_fl[k] = f;
                    end else begin
                        m_valid[k] = 1; m_res[k] = r; m_hi[k] = h; m_fl[k] = f;
                    end
                end
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 2; k++) begin
                string nm;
                bit    g_ov, g_rdy, g_busy, x_rdy;
                longint g_res, g_hi;
                int    g_fl;
                nm = $sformatf("d%0d", mw[k]);
                if (k == 0) begin
                    g_ov = ov8; g_rdy = rdy8; g_busy = busy8; g_res = res8; g_hi = hi8; g_fl = fl8;
                end else begin
                    g_ov = ov16; g_rdy = rdy16; g_busy = busy16; g_res = res16; g_hi = hi16; g_fl = fl16;
                end
                x_rdy = (m_busy[k] == 0) && (!m_valid[k] || out_ready_s);
                chk({nm, " out_valid"}, g_ov, m_valid[k]);
                chk({nm, " in_ready"}, g_rdy, x_rdy);
                chk({nm, " busy"}, g_busy, (m_busy[k] > 0) ? 1 : 0);
                chk({nm, " result"}, g_res, m_res[k]);
                chk({nm, " result_hi"}, g_hi, m_hi[k]);
                chk({nm, " flags"}, g_fl, m_fl[k]);
            end
        end
    end

    // Present one op until the 8-bit instance takes it, then measure latency and busy cycles.
    task automatic run_op(input int op, input int a, input int b, output int lat, output int busyc);
        int n;
        @(negedge clk); #1;
        op_s = 3'(op); a_s = 16'(a); b_s = 16'(b); in_valid_s = 1'b1; out_ready_s = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!m_acc[0] && n < 40);
        in_valid_s = 1'b0;
        if (!m_acc[0]) chk("accept timeout", 0, 1);
        lat = 1; busyc = 0;
        while (!ov8 && lat < 40) begin
            busyc += int'(busy8);
            @(posedge clk); #1;
            lat++;
        end
        if (!ov8) chk("completion timeout", 0, 1);
    endtask

    initial begin
        int lat, bc;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset out_valid", ov8, 0);
        chk("reset busy", busy8, 0);
        chk("reset result", res8, 0);
        chk("reset flags", fl8, 0);
        @(negedge clk); #1; rst_n = 1'b1;
        @(posedge clk); #1;
        chk("in_ready after reset", rdy8, 1);

        run_op(OPADD, 16'hFFFF, 16'h0001, lat, bc);
        chk("add wrap lat", lat, 1);
        chk("add wrap d8 result", res8, 8'h00);
        chk("add wrap d8 flags", fl8, 4'h3);
        chk("add wrap d16 result", res16, 16'h0000);
        chk("add wrap d16 flags", fl16, 4'h3);

        run_op(OPADD, 16'h007F, 16'h0001, lat, bc);
        chk("add ovf result", res8, 8'h80);
        chk("add ovf flags", fl8, 4'hC);

        run_op(OPCMP, 5, 5, lat, bc);
        chk("cmp eq result kept", res8, 8'h80);
        chk("cmp eq flags", fl8, 4'h2);

        run_op(OPSUB, 16'h0010, 16'h0020, lat, bc);
        chk("sub borrow result", res8, 8'hF0);
        chk("sub borrow flags", fl8, 4'h5);

        run_op(OPCMP, 3, 4, lat, bc);
        chk("cmp lt result kept", res8, 8'hF0);
        chk("cmp lt flags", fl8, 4'h5);

        run_op(OPMUL, 16'h000F, 16'h0011, lat, bc);
        chk("mul lat", lat, 9);
        chk("mul busy cycles", bc, 8);
        chk("mul lo", res8, 8'hFF);
        chk("mul hi", hi8, 8'h00);
        chk("mul flags", fl8, 4'h0);
        chk("d16 nomul result", res16, 0);
        chk("d16 nomul flags", fl16, 0);

        run_op(OPMUL, 16'h00FF, 16'h00FF, lat, bc);
        chk("mul max lo", res8, 8'h01);
        chk("mul max hi", hi8, 8'hFE);
        chk("mul max flags", fl8, 4'h5);

        // Backpressure: hold a result for five cycles, then consume it while issuing the next op.
        @(negedge clk); #1; out_ready_s = 1'b1; in_valid_s = 1'b0;
        @(negedge clk); #1;
        out_ready_s = 1'b0; op_s = 3'(OPADD); a_s = 16'd1; b_s = 16'd2; in_valid_s = 1'b1;
        @(posedge clk); #1; in_valid_s = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp out_valid held", ov8, 1);
            chk("bp in_ready low", rdy8, 0);
            chk("bp result held", res8, 8'h03);
        end
        @(negedge clk); #1;
        out_ready_s = 1'b1; op_s = 3'(OPXOR); a_s = 16'h000F; b_s = 16'h00F0; in_valid_s = 1'b1;
        @(posedge clk); #1; in_valid_s = 1'b0;
        chk("bp next accepted valid", ov8, 1);
        chk("bp next result", res8, 8'hFF);
        chk("bp next flags", fl8, 4'h4);

        // Reset during a multiply.
        @(negedge clk); #1;
        op_s = 3'(OPMUL); a_s = 16'h0023; b_s = 16'h0045; in_valid_s = 1'b1; out_ready_s = 1'b1;
        @(posedge clk); #1; in_valid_s = 1'b0;
        repeat (3) @(posedge clk);
        #2; rst_n = 1'b0;
        #1;
        chk("abort out_valid", ov8, 0);
        chk("abort busy", busy8, 0);
        chk("abort result", res8, 0);
        chk("abort flags", fl8, 0);
        @(posedge clk);
        @(negedge clk); #1; rst_n = 1'b1;
        run_op(OPADD, 3, 4, lat, bc);
        chk("post-abort add lat", lat, 1);
        chk("post-abort add result", res8, 8'h07);

        // Random traffic, checked every cycle by the compare process.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk); #1;
            in_valid_s  = ($urandom_range(0, 9) < 7);
            out_ready_s = ($urandom_range(0, 9) < 7);
            op_s        = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 5))
                0: a_s = 16'hFFFF;
                1: a_s = 16'h7FFF;
                2: a_s = 16'h007F;
                default: a_s = 16'($urandom);
            endcase
            case ($urandom_range(0, 5))
                0: b_s = 16'h0001;
                1: b_s = a_s;
                default: b_s = 16'($urandom);
            endcase
        end
        @(negedge clk); #1; in_valid_s = 1'b0; out_ready_s = 1'b1;
        repeat (12) @(posedge clk);
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
